// File: rtl/flex_tap_line.sv
// flex_tap_line
//   Signed sample delay line for the FIR datapath. Holds the NUM_TAPS most
//   recent samples: tap[0] is the newest and tap[NUM_TAPS-1] the oldest.
//   Every tap is exposed in parallel, and one tap can be picked with tap_sel.
//   A saturating fill counter reports how many valid samples are held.
//
// Parameters
//   NUM_BITS : width of each signed sample/tap
//   NUM_TAPS : delay-line depth, 2..64
//   SEL_BITS : width of tap_sel, must equal $clog2(NUM_TAPS)
//
// Ports
//   clk          : rising-edge clock
//   n_reset      : asynchronous, active-low reset
//   shift_enable : accept new_sample on this edge
//   clear        : synchronous flush of taps and fill count (beats shift_enable)
//   new_sample   : sample shifted into tap 0
//   tap_sel      : index of the tap driven onto tap_value
//   tap_value    : combinational read of tap[tap_sel], 0 when tap_sel >= NUM_TAPS
//   all_taps     : flattened taps, tap[i] at [(i+1)*NUM_BITS-1 : i*NUM_BITS]
//   fill_count   : number of valid samples held, 0..NUM_TAPS
//   full         : fill_count == NUM_TAPS
//   shift_done   : registered one-cycle pulse after each accepted shift
//
// Handshake: there is no back-pressure. A sample is accepted on every rising
// edge where shift_enable=1 and clear=0; shift_done follows one cycle later
// and stays high across back-to-back accepted shifts.

module flex_tap_line #(
    parameter int NUM_BITS = 16,
    parameter int NUM_TAPS = 4,
    parameter int SEL_BITS = 2
) (
    input  logic                         clk,
    input  logic                         n_reset,
    input  logic                         shift_enable,
    input  logic                         clear,
    input  logic signed [NUM_BITS-1:0]   new_sample,
    input  logic        [SEL_BITS-1:0]   tap_sel,
    output logic signed [NUM_BITS-1:0]   tap_value,
    output logic [NUM_BITS*NUM_TAPS-1:0] all_taps,
    output logic        [SEL_BITS:0]     fill_count,
    output logic                         full,
    output logic                         shift_done
);

    generate
        if (SEL_BITS != $clog2(NUM_TAPS)) begin : g_bad_sel_bits
            $error("flex_tap_line: SEL_BITS must equal $clog2(NUM_TAPS)");
        end
        if (NUM_TAPS < 2 || NUM_TAPS > 64) begin : g_bad_num_taps
            $error("flex_tap_line: NUM_TAPS must be in 2..64");
        end
    endgenerate

    localparam logic [SEL_BITS:0] FULL_COUNT = (SEL_BITS + 1)'(NUM_TAPS);
    localparam logic [SEL_BITS:0] ONE_COUNT  = {{SEL_BITS{1'b0}}, 1'b1};

    logic signed [NUM_BITS-1:0] taps [NUM_TAPS];
    logic        [SEL_BITS:0]   fill_count_q;
    logic                       shift_done_q;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                taps[i] <= '0;
            end
            fill_count_q <= '0;
            shift_done_q <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                taps[i] <= '0;
            end
            fill_count_q <= '0;
            shift_done_q <= 1'b0;
        end else if (shift_enable) begin
            taps[0] <= new_sample;
            for (int i = 1; i < NUM_TAPS; i++) begin
                taps[i] <= taps[i-1];
            end
            // Saturate so steady-state streaming never wraps the count.
            if (fill_count_q != FULL_COUNT) begin
                fill_count_q <= fill_count_q + ONE_COUNT;
            end
            shift_done_q <= 1'b1;
        end else begin
            shift_done_q <= 1'b0;
        end
    end

    // Compare against every legal index so out-of-range selects on
    // non-power-of-two depths fall through to zero.
    always_comb begin
        tap_value = '0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            if (tap_sel == SEL_BITS'(i)) begin
                tap_value = taps[i];
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_TAPS; g++) begin : g_flat
            assign all_taps[(g+1)*NUM_BITS-1 : g*NUM_BITS] = taps[g];
        end
    endgenerate

    assign fill_count = fill_count_q;
    assign full       = (fill_count_q == FULL_COUNT);
    assign shift_done = shift_done_q;

endmodule

// File: doc/flex_tap_line.md
Name: flex_tap_line

Overview:
- Parametrised signed sample delay line for the FIR datapath. Replaces chains of single-word write-enabled registers.
- Holds the NUM_TAPS most recent signed samples. Shifts in a new sample on each accepted enable.
- Exposes every tap in parallel, plus one selectable tap, to the MAC stage.
- Tracks fill level so the controller can suppress outputs until the window is primed.

Parameters:
- NUM_BITS, 16, width of each signed sample/tap.
- NUM_TAPS, 4, delay-line depth (number of stored samples); legal range 2..64.
- SEL_BITS, 2, width of tap_sel; must equal $clog2(NUM_TAPS) (elaboration-time assertion).

Ports:
- clk  input  1  system clock, rising-edge.
- n_reset  input  1  asynchronous, active-low reset.
- shift_enable  input  1  accept new_sample this cycle.
- clear  input  1  synchronous flush of all taps and fill count.
- new_sample  input  signed NUM_BITS  sample to shift into tap 0.
- tap_sel  input  SEL_BITS  index of tap driven onto tap_value.
- tap_value  output  signed NUM_BITS  combinational read of tap[tap_sel].
- all_taps  output  NUM_BITS*NUM_TAPS  flattened taps; tap[i] at bits [(i+1)*NUM_BITS-1 : i*NUM_BITS].
- fill_count  output  SEL_BITS+1  number of valid samples held, 0..NUM_TAPS.
- full  output  1  high when fill_count == NUM_TAPS.
- shift_done  output  1  registered one-cycle pulse after an accepted shift.

Behaviour:
- Storage: tap[0] is the newest sample; tap[NUM_TAPS-1] is the oldest.
- Reset (n_reset low, asynchronous, takes effect immediately regardless of clk):
  - all taps = 0
  - fill_count = 0
  - full = 0
  - shift_done = 0
- Reset release: first active edge is the first rising clk with n_reset high.
- Per rising edge, priority order:
  1. clear=1: all taps <= 0, fill_count <= 0, shift_done <= 0. A shift_enable in the same cycle is ignored.
  2. else shift_enable=1: tap[0] <= new_sample; tap[i] <= tap[i-1] for i=1..NUM_TAPS-1; old tap[NUM_TAPS-1] is discarded. fill_count <= min(fill_count+1, NUM_TAPS); shift_done <= 1.
  3. else: all state holds; shift_done <= 0.
- Latency:
  - new_sample appears on tap[0]/all_taps the cycle after the accepting edge.
  - A sample reaches tap[k] after k+1 accepted shifts.
  - Cycles without shift do not advance the line.
- fill_count: saturating counter.
  - Never wraps; stays at NUM_TAPS during steady-state streaming.
  - Returns to 0 only on clear or reset.
- full: combinational decode of the fill_count register.
- shift_done:
  - Asserted exactly one cycle per accepted shift.
  - Back-to-back shifts hold it high continuously.
- tap_value:
  - Purely combinational mux of the registered taps; no added latency.
  - tap_sel >= NUM_TAPS (non-power-of-two depths) drives 0.
- Arithmetic: no arithmetic on samples. Values pass bit-exact, sign preserved; no truncation or extension.
- X handling: new_sample is don't-care when shift_enable=0 or clear=1; it must not propagate.

Test Plan:
1. Reset, then shift 1, -2, 3, -4 on consecutive cycles (NUM_TAPS=4) -> taps {tap0..tap3} = {-4,3,-2,1}; fill_count = 1,2,3,4; full rises after the 4th shift; shift_done high for 4 cycles.
2. From the state in scenario 1, shift 5 -> taps {5,-4,3,-2}; value 1 dropped; fill_count stays 4; full stays 1.
3. shift_enable=1 and clear=1 in the same cycle with new_sample=7 -> all taps 0, fill_count 0, full 0, shift_done 0 next cycle; 7 never appears.
4. Idle 10 cycles with shift_enable=0 and new_sample toggling randomly -> taps, fill_count and all_taps unchanged; shift_done 0.
5. Sweep tap_sel 0..3 after scenario 2 -> tap_value = 5,-4,3,-2 in the same cycle. Build NUM_TAPS=3, SEL_BITS=2: tap_sel=3 -> tap_value=0.
6. Assert n_reset low mid-stream, between clock edges, after 2 shifts -> taps, fill_count and full go to 0 immediately. After release, the first shift of 9 gives tap0=9, fill_count=1.
